output_argmax: RTL and testbench
================================

// Module: output_argmax
// PURPOSE
//  Post-inference classifier stage downstream of the neurocore.
//  Scans the N_CLASS output-layer scores the core has written to output RAM.
//  Reads them through the RAM's second (read-only) port and reports the index of the maximum score.
//  Gives the host/top level the MNIST digit decision through a valid/ready handshake.
// PARAMETERS
//  N_CLASS    10         number of scores to scan (>=1)
//  BASE_ADDR  32'h0      byte address of score[0] in output RAM
//  DATA_W     16         score width; signed two's complement, in dout[DATA_W-1:0]
//  IDX_W      4          width of class index, >= clog2(N_CLASS)
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous reset, active low
//  start      in   1       one-cycle request to scan; sampled only in IDLE
//  busy       out  1       high from accepted start until res_valid rises
//  rd_addr    out  32      output RAM byte address, BASE_ADDR + 4*i
//  rd_en      out  1       output RAM enable
//  rd_we      out  4       output RAM write strobes, constant 4'b0000
//  rd_dout    in   32      output RAM read data, 1-cycle registered latency
//  res_valid  out  1       result available; held until accepted
//  res_ready  in   1       consumer accepts result when res_valid & res_ready
//  res_idx    out  IDX_W   index of maximum score
//  res_score  out  DATA_W  maximum score (present only with ARGMAX_SCORE_OUT_EN)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - State is IDLE.
//   - busy, rd_en, res_valid and rd_addr are 0; res_idx is 0; res_score is 0.
//   - Reset mid-scan aborts the scan with no result.
//  FSM: IDLE -> READ -> DRAIN -> DONE -> IDLE.
//   - IDLE:  start=1 -> READ, with rd_idx=0. start is ignored in every other state.
//   - READ:  rd_en=1 and rd_addr=BASE_ADDR+4*rd_idx; rd_idx increments every cycle.
//            Leaves for DRAIN after issuing rd_idx=N_CLASS-1.
//   - DRAIN: rd_en=0; compares the last returned word; then -> DONE.
//   - DONE:  res_valid=1 with res_idx/res_score stable; busy=0.
//            res_ready=1 -> IDLE and res_valid drops the next cycle.
//  Compare pipeline:
//   - Word j arrives one cycle after its address is issued.
//   - j=0 loads max=score0, idx=0 unconditionally, so all-negative scores work.
//   - For j>0, max and idx are replaced only when score_j > max, signed compare.
//   - Ties resolve to the lowest index.
//  Latency:
//   - res_valid rises N_CLASS+1 cycles after the edge that samples start (11 for default).
//  Boundaries:
//   - N_CLASS=1: one read, result idx 0.
//   - rd_idx counter never wraps; it stops at N_CLASS-1.
//   - Bits [31:DATA_W] of rd_dout are ignored.
//   - start and res_ready both high in DONE: start is ignored; DONE -> IDLE only.
//   - res_ready while not in DONE is ignored.
//  Exclusion: the top level sequences the core and this block so the core does not write output RAM during a scan.
// CONFIGURATION
//  `ARGMAX_SCORE_OUT_EN
//   - Defined: port res_score exists and carries the maximum score, valid with res_valid.
//   - Undefined: the port and its register are absent; only the index is produced.
// STRUCTURE
//  def.h gains:
//   - `AM_STAT_W and state codes `AM_IDLE/`AM_READ/`AM_DRAIN/`AM_DONE (one-hot, like STAT_*).
//   - `SCORE_W aliasing DATA_W.
//  Sub-module argmax_cmp: registered signed max/index tracker with load (first) and update inputs.
//  The FSM, address counter and handshake stay in output_argmax.
// TESTING
//  1. Scores 3,-1,7,2,7,0,0,0,0,0 and a start pulse:
//     res_valid 11 cycles after start; res_idx=2 (tie with 4 goes low); res_score=7.
//  2. All ten scores 16'h8000..8009 (negative):
//     res_idx=9, res_score=16'h8009; proves no zero-initialised max.
//  3. res_ready held low 20 cycles after res_valid:
//     res_valid, res_idx and res_score stay stable; a start pulse meanwhile is ignored;
//     res_ready=1 -> IDLE next cycle.
//  4. rst_n pulsed low at READ cycle 4:
//     busy, rd_en and res_valid go 0 immediately; a later start gives a correct fresh result.
//  5. BASE_ADDR=32'h40:
//     rd_addr sequence 40,44,...,64; rd_we always 0; rd_en high exactly 10 cycles.
//  6. N_CLASS=1, score0=-5:
//     res_idx=0 and res_valid 2 cycles after start.

Source files
------------

// File: rtl/output_argmax_pkg.sv
// Shared types and helpers for the output_argmax classifier stage.
// Optional feature macro: ARGMAX_SCORE_OUT_EN (exports the winning score).
package output_argmax_pkg;

  localparam int AM_STAT_W = 4;

  // Default score width; the design parameter DATA_W carries the real value.
  localparam int SCORE_W = 16;

  // One-hot scan states, observable on the top-level state port.
  typedef enum logic [AM_STAT_W-1:0] {
    AM_IDLE  = 4'b0001,
    AM_READ  = 4'b0010,
    AM_DRAIN = 4'b0100,
    AM_DONE  = 4'b1000
  } am_state_e;

  // Byte address of score word idx (one 32-bit word per score).
  function automatic logic [31:0] score_addr(input logic [31:0] base,
                                             input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/output_argmax_if.sv
// Host/RAM-facing bundle of output_argmax.
// Optional feature macro: ARGMAX_SCORE_OUT_EN adds res_score and DATA_W.
//
// Result handshake: res_valid rises with res_idx/res_score already stable and
// stays high, with those values unchanged, until a cycle where res_ready is
// also high; that cycle is the transfer. res_ready is ignored while res_valid
// is low. start is a one-cycle request honoured only while the block is idle.
interface output_argmax_if #(
  parameter int IDX_W = 4
`ifdef ARGMAX_SCORE_OUT_EN
  , parameter int DATA_W = 16
`endif
);

  logic             start;
  logic             busy;
  logic [31:0]      rd_addr;
  logic             rd_en;
  logic [3:0]       rd_we;
  logic [31:0]      rd_dout;
  logic             res_valid;
  logic             res_ready;
  logic [IDX_W-1:0] res_idx;
`ifdef ARGMAX_SCORE_OUT_EN
  logic [DATA_W-1:0] res_score;
`endif

`ifdef ARGMAX_SCORE_OUT_EN
  modport master (
    output start, rd_dout, res_ready,
    input  busy, rd_addr, rd_en, rd_we, res_valid, res_idx, res_score
  );
  modport slave (
    input  start, rd_dout, res_ready,
    output busy, rd_addr, rd_en, rd_we, res_valid, res_idx, res_score
  );
`else
  modport master (
    output start, rd_dout, res_ready,
    input  busy, rd_addr, rd_en, rd_we, res_valid, res_idx
  );
  modport slave (
    input  start, rd_dout, res_ready,
    output busy, rd_addr, rd_en, rd_we, res_valid, res_idx
  );
`endif

endinterface

// File: rtl/output_argmax_cmp.sv
// Registered signed running-maximum tracker with its class index.
// load takes the word unconditionally (first score); update replaces the
// held maximum only on a strictly greater score, so ties keep the lower index.
module output_argmax_cmp #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     update,
  input  logic signed [DATA_W-1:0] score,
  input  logic        [IDX_W-1:0]  idx,
  output logic signed [DATA_W-1:0] max_score,
  output logic        [IDX_W-1:0]  max_idx
);

  // Track the maximum score and where it was found.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_score <= '0;
      max_idx   <= '0;
    end else if (load) begin
      max_score <= score;
      max_idx   <= idx;
    end else if (update && (score > max_score)) begin
      max_score <= score;
      max_idx   <= idx;
    end
  end

endmodule

// File: rtl/output_argmax.sv
// Post-inference argmax: reads N_CLASS signed scores from output RAM through
// its read-only port and reports the index of the largest one.
// Optional feature macro: ARGMAX_SCORE_OUT_EN also exports the winning score
// (the interface's DATA_W must then match this module's DATA_W).
module output_argmax
  import output_argmax_pkg::*;
#(
  parameter int          N_CLASS   = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          DATA_W    = 16,
  parameter int          IDX_W     = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  output_argmax_if.slave bus,
  output am_state_e state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASS - 1);

  am_state_e        state_q, state_d;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_en;
  logic             cmp_en;
  logic             cmp_first;
  logic [IDX_W-1:0] cmp_idx;
  logic signed [DATA_W-1:0] max_score;
  logic        [IDX_W-1:0]  max_idx;
  logic             rd_dout_unused;

  assign state = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= AM_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: one pass of reads, one cycle to absorb the last word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      AM_IDLE:  if (bus.start)          state_d = AM_READ;
      AM_READ:  if (rd_idx == LAST_IDX) state_d = AM_DRAIN;
      AM_DRAIN:                         state_d = AM_DONE;
      AM_DONE:  if (bus.res_ready)      state_d = AM_IDLE;
      default:                          state_d = AM_IDLE;
    endcase
  end

  assign rd_en         = (state_q == AM_READ);
  assign bus.rd_en     = rd_en;
  assign bus.rd_we     = 4'b0000;
  assign bus.rd_addr   = rd_en ? score_addr(BASE_ADDR, 32'(rd_idx)) : 32'h0;
  assign bus.busy      = (state_q == AM_READ) || (state_q == AM_DRAIN);
  assign bus.res_valid = (state_q == AM_DONE);
  assign bus.res_idx   = max_idx;

  // Read index: cleared on an accepted start, saturates at the last class.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx <= '0;
    end else if ((state_q == AM_IDLE) && bus.start) begin
      rd_idx <= '0;
    end else if ((state_q == AM_READ) && (rd_idx != LAST_IDX)) begin
      rd_idx <= rd_idx + 1'b1;
    end
  end

  // Delay the read strobe and index by the RAM latency so they line up with rd_dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_en    <= 1'b0;
      cmp_first <= 1'b0;
      cmp_idx   <= '0;
    end else begin
      cmp_en    <= rd_en;
      cmp_first <= rd_en && (rd_idx == '0);
      cmp_idx   <= rd_idx;
    end
  end

  output_argmax_cmp #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_cmp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cmp_en && cmp_first),
    .update    (cmp_en && !cmp_first),
    .score     (bus.rd_dout[DATA_W-1:0]),
    .idx       (cmp_idx),
    .max_score (max_score),
    .max_idx   (max_idx)
  );

  // Only the low DATA_W bits of a RAM word hold the score.
  assign rd_dout_unused = ^bus.rd_dout[31:DATA_W];

`ifdef ARGMAX_SCORE_OUT_EN
  assign bus.res_score = max_score;
`else
  logic score_unused;
  assign score_unused = ^max_score;
`endif

endmodule

// File: tb/tb_output_argmax.sv
// Directed bench for output_argmax: three instances (default, BASE_ADDR=0x40,
// N_CLASS=1) each with a registered one-cycle-latency RAM model.
module tb_output_argmax;
  import output_argmax_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  output_argmax_if am ();
  output_argmax_if am40 ();
  output_argmax_if am1 ();

  am_state_e st, st40, st1;

  output_argmax #(.N_CLASS(10), .BASE_ADDR(32'h0), .DATA_W(16), .IDX_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(am), .state(st));
  output_argmax #(.N_CLASS(10), .BASE_ADDR(32'h40), .DATA_W(16), .IDX_W(4)) u_dut40 (
    .clk(clk), .rst_n(rst_n), .bus(am40), .state(st40));
  output_argmax #(.N_CLASS(1), .BASE_ADDR(32'h0), .DATA_W(16), .IDX_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(am1), .state(st1));

  logic [31:0] mem0  [10];
  logic [31:0] mem40 [10];
  logic [31:0] mem1  [1];

  // RAM models: registered read, one cycle latency.
  always @(posedge clk) begin
    if (am.rd_en)   am.rd_dout   <= mem0[am.rd_addr[5:2]];
    if (am40.rd_en) am40.rd_dout <= mem40[am40.rd_addr[5:2]];
    if (am1.rd_en)  am1.rd_dout  <= mem1[0];
  end

  function automatic logic [31:0] w(input int v);
    logic [15:0] s;
    s = 16'(v);
    return {16'h0000, s};
  endfunction

  // Pulse start on the default instance and count cycles until res_valid.
  task automatic run_scan(output int lat, output logic busy_seen);
    am.start = 1'b1;
    @(negedge clk);
    am.start = 1'b0;
    busy_seen = am.busy;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (am.res_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (am.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", am.busy); end
    vectors++; if (am.rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en: got %0b want 0", am.rd_en); end
    vectors++; if (am.res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid: got %0b want 0", am.res_valid); end
    vectors++; if (am.rd_addr !== 32'h0) begin miscompares++; $display("FAIL reset_rd_addr: got %0h want 0", am.rd_addr); end
    vectors++; if (am.res_idx !== 4'd0) begin miscompares++; $display("FAIL reset_res_idx: got %0d want 0", am.res_idx); end
    vectors++; if (st !== AM_IDLE) begin miscompares++; $display("FAIL reset_state: got %0h want %0h", st, AM_IDLE); end
`ifdef ARGMAX_SCORE_OUT_EN
    vectors++; if (am.res_score !== 16'h0) begin miscompares++; $display("FAIL reset_res_score: got %0h want 0", am.res_score); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (st !== AM_IDLE) begin miscompares++; $display("FAIL post_reset_state: got %0h want %0h", st, AM_IDLE); end
  endtask

  task automatic test_tie_low();
    int   lat;
    logic b;
    mem0 = '{w(3), w(-1), w(7), w(2), w(7), w(0), w(0), w(0), w(0), w(0)};
    run_scan(lat, b);
    vectors++; if (b !== 1'b1) begin miscompares++; $display("FAIL tie_busy: got %0b want 1", b); end
    vectors++; if (lat !== 11) begin miscompares++; $display("FAIL tie_latency: got %0d want 11", lat); end
    vectors++; if (am.res_idx !== 4'd2) begin miscompares++; $display("FAIL tie_idx: got %0d want 2", am.res_idx); end
    vectors++; if (am.busy !== 1'b0) begin miscompares++; $display("FAIL tie_busy_done: got %0b want 0", am.busy); end
`ifdef ARGMAX_SCORE_OUT_EN
    vectors++; if (am.res_score !== 16'd7) begin miscompares++; $display("FAIL tie_score: got %0h want 7", am.res_score); end
`endif
    am.res_ready = 1'b1;
    @(negedge clk);
    am.res_ready = 1'b0;
    vectors++; if (am.res_valid !== 1'b0) begin miscompares++; $display("FAIL tie_accept_valid: got %0b want 0", am.res_valid); end
    vectors++; if (st !== AM_IDLE) begin miscompares++; $display("FAIL tie_accept_state: got %0h want %0h", st, AM_IDLE); end
  endtask

  // Negative scores with upper RAM bits set; res_ready held high during the scan.
  task automatic test_all_negative();
    int   lat;
    logic b;
    for (int k = 0; k < 10; k++) mem0[k] = 32'hFFFF_8000 + 32'(k);
    am.res_ready = 1'b1;
    run_scan(lat, b);
    vectors++; if (lat !== 11) begin miscompares++; $display("FAIL neg_latency: got %0d want 11", lat); end
    vectors++; if (am.res_idx !== 4'd9) begin miscompares++; $display("FAIL neg_idx: got %0d want 9", am.res_idx); end
`ifdef ARGMAX_SCORE_OUT_EN
    vectors++; if (am.res_score !== 16'h8009) begin miscompares++; $display("FAIL neg_score: got %0h want 8009", am.res_score); end
`endif
    @(negedge clk);
    am.res_ready = 1'b0;
    vectors++; if (am.res_valid !== 1'b0) begin miscompares++; $display("FAIL neg_accept_valid: got %0b want 0", am.res_valid); end
  endtask

  task automatic test_hold();
    int   lat;
    logic b;
    run_scan(lat, b);
    vectors++; if (lat !== 11) begin miscompares++; $display("FAIL hold_latency: got %0d want 11", lat); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if (am.res_valid !== 1'b1 || am.res_idx !== 4'd9 || st !== AM_DONE) begin
        miscompares++;
        $display("FAIL hold_stable[%0d]: got valid=%0b idx=%0d state=%0h want valid=1 idx=9 state=%0h",
                 i, am.res_valid, am.res_idx, st, AM_DONE);
      end
`ifdef ARGMAX_SCORE_OUT_EN
      vectors++; if (am.res_score !== 16'h8009) begin miscompares++; $display("FAIL hold_score[%0d]: got %0h want 8009", i, am.res_score); end
`endif
      if (i == 5) am.start = 1'b1;
      if (i == 6) am.start = 1'b0;
    end
    vectors++; if (am.busy !== 1'b0) begin miscompares++; $display("FAIL hold_busy: got %0b want 0", am.busy); end
    am.start = 1'b1;
    am.res_ready = 1'b1;
    @(negedge clk);
    am.start = 1'b0;
    am.res_ready = 1'b0;
    vectors++; if (st !== AM_IDLE) begin miscompares++; $display("FAIL hold_exit_state: got %0h want %0h", st, AM_IDLE); end
    vectors++; if (am.res_valid !== 1'b0) begin miscompares++; $display("FAIL hold_exit_valid: got %0b want 0", am.res_valid); end
    @(negedge clk);
    vectors++; if (am.busy !== 1'b0 || st !== AM_IDLE) begin miscompares++; $display("FAIL hold_start_ignored: got busy=%0b state=%0h want busy=0 state=%0h", am.busy, st, AM_IDLE); end
  endtask

  task automatic test_reset_mid_scan();
    int   lat;
    logic b;
    mem0 = '{w(5), w(9), w(-3), w(9), w(0), w(1), w(2), w(8), w(4), w(6)};
    am.start = 1'b1;
    @(negedge clk);
    am.start = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (st !== AM_READ || am.rd_addr !== 32'h10) begin miscompares++; $display("FAIL mid_read4: got state=%0h addr=%0h want state=%0h addr=10", st, am.rd_addr, AM_READ); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (am.busy !== 1'b0 || am.rd_en !== 1'b0 || am.res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got busy=%0b rd_en=%0b valid=%0b want 0 0 0", am.busy, am.rd_en, am.res_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_scan(lat, b);
    vectors++; if (lat !== 11) begin miscompares++; $display("FAIL fresh_latency: got %0d want 11", lat); end
    vectors++; if (am.res_idx !== 4'd1) begin miscompares++; $display("FAIL fresh_idx: got %0d want 1", am.res_idx); end
`ifdef ARGMAX_SCORE_OUT_EN
    vectors++; if (am.res_score !== 16'd9) begin miscompares++; $display("FAIL fresh_score: got %0h want 9", am.res_score); end
`endif
    am.res_ready = 1'b1;
    @(negedge clk);
    am.res_ready = 1'b0;
  endtask

  // BASE_ADDR=0x40: address sequence, write strobes, read count, upper bits ignored.
  task automatic test_base_addr();
    int en_cnt = 0;
    int lat = 0;
    for (int k = 0; k < 10; k++) mem40[k] = {16'hFFFF, 16'(k + 1)};
    mem40[3] = {16'h0000, 16'h0050};
    mem40[7] = {16'h7FFF, 16'h0050};
    am40.start = 1'b1;
    @(negedge clk);
    am40.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      vectors++; if (am40.rd_we !== 4'b0000) begin miscompares++; $display("FAIL base_rd_we: got %0h want 0", am40.rd_we); end
      if (am40.rd_en) begin
        vectors++;
        if (am40.rd_addr !== 32'h40 + 32'(4 * en_cnt)) begin
          miscompares++;
          $display("FAIL base_rd_addr[%0d]: got %0h want %0h", en_cnt, am40.rd_addr, 32'h40 + 32'(4 * en_cnt));
        end
        en_cnt++;
      end
      if (am40.res_valid) begin
        lat = c - 1;
        break;
      end
      @(negedge clk);
    end
    vectors++; if (en_cnt !== 10) begin miscompares++; $display("FAIL base_rd_en_count: got %0d want 10", en_cnt); end
    vectors++; if (lat !== 11) begin miscompares++; $display("FAIL base_latency: got %0d want 11", lat); end
    vectors++; if (am40.res_idx !== 4'd3) begin miscompares++; $display("FAIL base_idx: got %0d want 3", am40.res_idx); end
`ifdef ARGMAX_SCORE_OUT_EN
    vectors++; if (am40.res_score !== 16'h0050) begin miscompares++; $display("FAIL base_score: got %0h want 50", am40.res_score); end
`endif
    am40.res_ready = 1'b1;
    @(negedge clk);
    am40.res_ready = 1'b0;
  endtask

  task automatic test_single_class();
    int lat = 0;
    mem1[0] = 32'h1234_FFFB;
    am1.start = 1'b1;
    @(negedge clk);
    am1.start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (am1.res_valid) begin
        lat = c;
        break;
      end
    end
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL single_latency: got %0d want 2", lat); end
    vectors++; if (am1.res_idx !== 4'd0) begin miscompares++; $display("FAIL single_idx: got %0d want 0", am1.res_idx); end
`ifdef ARGMAX_SCORE_OUT_EN
    vectors++; if (am1.res_score !== 16'hFFFB) begin miscompares++; $display("FAIL single_score: got %0h want fffb", am1.res_score); end
`endif
    am1.res_ready = 1'b1;
    @(negedge clk);
    am1.res_ready = 1'b0;
    vectors++; if (st1 !== AM_IDLE) begin miscompares++; $display("FAIL single_accept_state: got %0h want %0h", st1, AM_IDLE); end
  endtask

  initial begin
    am.start = 1'b0;   am.res_ready = 1'b0;   am.rd_dout = 32'h0;
    am40.start = 1'b0; am40.res_ready = 1'b0; am40.rd_dout = 32'h0;
    am1.start = 1'b0;  am1.res_ready = 1'b0;  am1.rd_dout = 32'h0;
    test_reset();
    test_tie_low();
    test_all_negative();
    test_hold();
    test_reset_mid_scan();
    test_base_addr();
    test_single_class();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
